// File: rtl/cache_refill_responder.sv
// cache_refill_responder: block-burst backing memory with fixed latency; `MEM_PRELOAD_EN presets mem[i] = i ^ 8'h5A instead of zeros.
module cache_refill_responder #(
  parameter int MEM_DEPTH  = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int LATENCY    = 4
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [7:0]  rdata,
  output logic        rdata_last,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [7:0]  wdata,
  output logic        wr_done,
  output logic        busy
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int OFF_WIDTH  = $clog2(BLOCK_SIZE);
  localparam int BASE_WIDTH = ADDR_WIDTH - OFF_WIDTH;
  typedef enum logic [2:0] {IDLE, WAIT, RD_BURST, WR_BURST, WR_ACK} state_t;
  typedef logic [MEM_DEPTH-1:0][7:0] mem_t;
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < MEM_DEPTH; i++)
`ifdef MEM_PRELOAD_EN
      m[i] = 8'(i) ^ 8'h5A;
`else
      m[i] = 8'h00;
`endif
    return m;
  endfunction
  mem_t mem = init_mem();
  state_t state, state_nx;
  logic [BASE_WIDTH-1:0] base;
  logic [OFF_WIDTH-1:0]  beat;
  logic [7:0]            lat_cnt;
  logic                  is_write;
  logic req_hs, rd_hs, wr_hs, last_beat, rd_load;
  logic [BASE_WIDTH-1:0] rd_base;
  logic [OFF_WIDTH-1:0]  rd_off;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH], req_addr[OFF_WIDTH-1:0]};
  assign req_ready   = state == IDLE;
  assign busy        = state != IDLE;
  assign rdata_valid = state == RD_BURST;
  assign wdata_ready = state == WR_BURST;
  assign wr_done     = state == WR_ACK;
  assign last_beat   = &beat;
  assign rdata_last  = rdata_valid && last_beat;
  assign req_hs      = req_valid && req_ready;
  assign rd_hs       = rdata_valid && rdata_ready;
  assign wr_hs       = wdata_valid && wdata_ready;
  // With zero latency the first beat is fetched on the accepting edge, before base is latched
  assign rd_base = state == IDLE ? req_addr[ADDR_WIDTH-1:OFF_WIDTH] : base;
  assign rd_off  = state == RD_BURST ? beat + 1'b1 : '0;
  assign rd_addr = {rd_base, rd_off};
  assign wr_addr = {base, beat};
  assign rd_load = rd_hs || (state_nx == RD_BURST && state != RD_BURST);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req_valid) state_nx = LATENCY == 0 ? (req_write ? WR_BURST : RD_BURST) : WAIT;
      WAIT:     if (lat_cnt == '0) state_nx = is_write ? WR_BURST : RD_BURST;
      RD_BURST: if (rdata_ready && last_beat) state_nx = IDLE;
      WR_BURST: if (wdata_valid && last_beat) state_nx = WR_ACK;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      base     <= '0;
      beat     <= '0;
      lat_cnt  <= '0;
      is_write <= 1'b0;
      rdata    <= '0;
    end else begin
      state <= state_nx;
      if (req_hs) begin
        is_write <= req_write;
        base     <= req_addr[ADDR_WIDTH-1:OFF_WIDTH];
        beat     <= '0;
        lat_cnt  <= 8'(LATENCY);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (rd_hs || wr_hs) beat <= beat + 1'b1;
      if (rd_load) rdata <= mem[rd_addr];
    end
  end
  always_ff @(posedge clk)
    if (reset_n && wr_hs) mem[wr_addr] <= wdata;
endmodule

// File: tb/tb_cache_refill_responder.sv
// tb_cache_refill_responder: directed checks of latency, read/write bursts, throttling, alignment, reset abort and zero latency.
module tb_cache_refill_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rdata_ready = 1'b0, wdata_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  wdata = '0;
  logic        req_ready, rdata_valid, rdata_last, wdata_ready, wr_done, busy;
  logic [7:0]  rdata;
  logic        f_req_valid = 1'b0, f_req_write = 1'b0, f_rdata_ready = 1'b0, f_wdata_valid = 1'b0;
  logic [31:0] f_req_addr = '0;
  logic [7:0]  f_wdata = '0;
  logic        f_req_ready, f_rdata_valid, f_rdata_last, f_wdata_ready, f_wr_done, f_busy;
  logic [7:0]  f_rdata;
  int checks = 0, errors = 0;

  cache_refill_responder dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .wr_done(wr_done), .busy(busy)
  );
  cache_refill_responder #(.LATENCY(0)) u_fast (
    .clk(clk), .reset_n(reset_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_write(f_req_write), .req_addr(f_req_addr), .rdata_valid(f_rdata_valid),
    .rdata_ready(f_rdata_ready), .rdata(f_rdata), .rdata_last(f_rdata_last),
    .wdata_valid(f_wdata_valid), .wdata_ready(f_wdata_ready), .wdata(f_wdata),
    .wr_done(f_wr_done), .busy(f_busy)
  );

  function automatic logic [7:0] pre(input int a);
`ifdef MEM_PRELOAD_EN
    return 8'(a) ^ 8'h5A;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_block(input logic [31:0] a, input logic toggle, output logic [7:0] q [16],
                            output int n, output int lat, output int last_err, output int stable_err,
                            output logic idle_after);
    logic phase, hold;
    logic [7:0] held;
    int guard;
    for (int i = 0; i < 16; i++) q[i] = 'x;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rdata_valid && lat < 50) begin tick(); lat++; end
    n = 0; last_err = 0; stable_err = 0; phase = 1'b1; guard = 0;
    while (n < 16 && guard < 200) begin
      rdata_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      if (rdata_valid && rdata_ready) begin
        q[n] = rdata;
        if (rdata_last !== (n == 15)) last_err++;
        n++;
        tick();
      end else begin
        held = rdata; hold = rdata_valid;
        tick();
        if (hold && rdata !== held) stable_err++;
      end
      guard++;
    end
    rdata_ready = 1'b0;
    idle_after = req_ready;
  endtask

  task automatic write_block(input logic [31:0] a, input logic [7:0] d [16], input int nb,
                             output int hs, output logic done_first, output int done_cnt);
    int g;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    g = 0;
    while (!wdata_ready && g < 50) begin tick(); g++; end
    hs = 0;
    for (int i = 0; i < nb; i++) begin
      wdata_valid = 1'b1; wdata = d[i];
      if (wdata_ready) hs++;
      tick();
    end
    wdata_valid = 1'b0;
    done_first = wr_done;
    done_cnt = 0;
    if (nb == 16) begin
      done_cnt = int'(wr_done);
      repeat (4) begin tick(); done_cnt += int'(wr_done); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({req_ready, busy, rdata_valid, rdata_last, wdata_ready, wr_done, rdata} !== {6'b100000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", {req_ready, busy, rdata_valid, rdata_last, wdata_ready, wr_done, rdata}, {6'b100000, 8'h00});
    end
    checks++;
    if ({f_req_ready, f_busy, f_rdata_valid, f_rdata_last, f_wdata_ready, f_wr_done, f_rdata} !== {6'b100000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs_fast got=%b exp=%b", {f_req_ready, f_busy, f_rdata_valid, f_rdata_last, f_wdata_ready, f_wr_done, f_rdata}, {6'b100000, 8'h00});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_refill_latency();
    logic [7:0] q [16];
    int n, lat, le, se;
    logic idle;
    read_block(32'h0000_1000, 1'b0, q, n, lat, le, se, idle);
    checks++; if (lat !== 5) begin errors++; $display("FAIL t1_latency got=%0d exp=5", lat); end
    checks++; if (n !== 16) begin errors++; $display("FAIL t1_beats got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q[i] !== pre(i)) begin errors++; $display("FAIL t1_data[%0d] got=%h exp=%h", i, q[i], pre(i)); end
    end
    checks++; if (le !== 0) begin errors++; $display("FAIL t1_last got=%0d bad beats exp=0", le); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL t1_ready_after got=%b exp=1", idle); end
  endtask

  task automatic test_writeback();
    logic [7:0] d [16], q [16];
    int hs, dc, n, lat, le, se;
    logic df, idle;
    for (int i = 0; i < 16; i++) d[i] = 8'hF0 + 8'(i);
    write_block(32'h100, d, 16, hs, df, dc);
    checks++; if (hs !== 16) begin errors++; $display("FAIL t2_handshakes got=%0d exp=16", hs); end
    checks++; if (df !== 1'b1) begin errors++; $display("FAIL t2_done_timing got=%b exp=1", df); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL t2_done_cycles got=%0d exp=1", dc); end
    read_block(32'h100, 1'b0, q, n, lat, le, se, idle);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q[i] !== d[i]) begin errors++; $display("FAIL t2_readback[%0d] got=%h exp=%h", i, q[i], d[i]); end
    end
  endtask

  task automatic test_throttled_read();
    logic [7:0] q [16];
    int n, lat, le, se;
    logic idle;
    read_block(32'h100, 1'b1, q, n, lat, le, se, idle);
    checks++; if (n !== 16) begin errors++; $display("FAIL t3_beats got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q[i] !== 8'hF0 + 8'(i)) begin errors++; $display("FAIL t3_data[%0d] got=%h exp=%h", i, q[i], 8'hF0 + 8'(i)); end
    end
    checks++; if (se !== 0) begin errors++; $display("FAIL t3_stable got=%0d unstable cycles exp=0", se); end
    checks++; if (le !== 0) begin errors++; $display("FAIL t3_last got=%0d bad beats exp=0", le); end
  endtask

  task automatic test_unaligned();
    logic [7:0] d [16], q [16];
    int hs, dc, n, lat, le, se;
    logic df, idle;
    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    write_block(32'h107, d, 16, hs, df, dc);
    checks++; if (hs !== 16) begin errors++; $display("FAIL t4_handshakes got=%0d exp=16", hs); end
    read_block(32'h10A, 1'b0, q, n, lat, le, se, idle);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q[i] !== 8'(i)) begin errors++; $display("FAIL t4_readback[%0d] got=%h exp=%h", i, q[i], 8'(i)); end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d [16], q [16], e;
    int hs, dc, n, lat, le, se;
    logic df, idle, seen;
    for (int i = 0; i < 16; i++) d[i] = 8'h11;
    write_block(32'h200, d, 8, hs, df, dc);
    reset_n = 1'b0;
    tick();
    checks++;
    if ({req_ready, busy} !== 2'b10) begin errors++; $display("FAIL t5_after_reset got=%b exp=10", {req_ready, busy}); end
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin seen |= wr_done; tick(); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL t5_no_done got=%b exp=0", seen); end
    read_block(32'h200, 1'b0, q, n, lat, le, se, idle);
    for (int i = 0; i < 16; i++) begin
      e = i < 8 ? 8'h11 : pre(32'h200 + i);
      checks++;
      if (q[i] !== e) begin errors++; $display("FAIL t5_readback[%0d] got=%h exp=%h", i, q[i], e); end
    end
  endtask

  task automatic test_zero_latency();
    logic [7:0] q [16];
    int n, le, g;
    for (int i = 0; i < 16; i++) q[i] = 'x;
    f_req_valid = 1'b1; f_req_write = 1'b0; f_req_addr = 32'h020; f_rdata_ready = 1'b1;
    tick();
    f_req_valid = 1'b0;
    checks++; if (f_rdata_valid !== 1'b1) begin errors++; $display("FAIL t6_first_beat got=%b exp=1", f_rdata_valid); end
    n = 0; le = 0; g = 0;
    while (n < 16 && g < 40) begin
      if (f_rdata_valid) begin
        q[n] = f_rdata;
        if (f_rdata_last !== (n == 15)) le++;
        n++;
      end
      tick();
      g++;
    end
    f_rdata_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (q[i] !== pre(32'h20 + i)) begin errors++; $display("FAIL t6_data[%0d] got=%h exp=%h", i, q[i], pre(32'h20 + i)); end
    end
    checks++; if (le !== 0) begin errors++; $display("FAIL t6_last got=%0d bad beats exp=0", le); end
    checks++; if (f_req_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_after got=%b exp=1", f_req_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_refill_latency();
    test_writeback();
    test_throttled_read();
    test_unaligned();
    test_reset_abort();
    test_zero_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
